// File: rtl/pic_inta_sequencer_if.sv
// Bus bundle for the PIC interrupt-acknowledge sequencer: request/EOI controls in,
// CPU-facing interrupt, vector and in-service status out.
interface pic_inta_sequencer_if;
    // inta_n is the CPU acknowledge strobe; the sequencer acts on its falling and rising
    // edges (REQ->ACK1 on fall, ACK1->WAIT2 on rise, WAIT2->ACK2 on fall, ACK2->IDLE on rise),
    // and data_out carries the vector only while data_oe is high.
    logic [7:0] irr_req;
    logic       inta_n;
    logic       eoi_cmd;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       eoi_rotate;
    logic       aeoi_en;
    logic       aeoi_rotate;
    logic [4:0] vector_base;
    logic       int_out;
    logic [7:0] irr_clr;
    logic [7:0] isr_cur;
    logic [7:0] data_out;
    logic       data_oe;
    logic [2:0] lowest_prio;
    logic [2:0] fsm_state;

    modport master (
        output irr_req, inta_n, eoi_cmd, eoi_specific, eoi_level, eoi_rotate,
               aeoi_en, aeoi_rotate, vector_base,
        input  int_out, irr_clr, isr_cur, data_out, data_oe, lowest_prio, fsm_state
    );

    modport slave (
        input  irr_req, inta_n, eoi_cmd, eoi_specific, eoi_level, eoi_rotate,
               aeoi_en, aeoi_rotate, vector_base,
        output int_out, irr_clr, isr_cur, data_out, data_oe, lowest_prio, fsm_state
    );
endinterface

// File: rtl/pic_inta_sequencer.sv
// 8259-style interrupt acknowledge sequencer: rotating-priority resolution, two-pulse
// INTA protocol, in-service register with normal/automatic EOI and priority rotation.
module pic_inta_sequencer (
    input  logic                  clk,
    input  logic                  rst_n,
    pic_inta_sequencer_if.slave   bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] ACK1  = 3'd2;
    localparam logic [2:0] WAIT2 = 3'd3;
    localparam logic [2:0] ACK2  = 3'd4;

    logic [2:0] state, state_n;
    logic       inta_q;
    logic [2:0] level, level_n;
    logic [7:0] isr_q, isr_n;
    logic [2:0] lp_q, lp_n;
    logic       int_q, int_n;
    logic [7:0] clr_q, clr_n;

    logic       fall, rise;
    logic [2:0] scan;
    logic       win_found, win_ok, win_valid, isr_found;
    logic [2:0] win_lvl, isr_lvl;
    logic [7:0] set_mask, aeoi_mask, eoi_mask;
    logic       aeoi_rot, eoi_rot;
    logic [2:0] eoi_rot_lvl;

    assign fall = inta_q & ~bus.inta_n;
    assign rise = ~inta_q & bus.inta_n;

    // Walk levels from highest to lowest priority; an in-service level met first blocks the winner.
    always_comb begin
        scan      = 3'd0;
        win_found = 1'b0;
        win_ok    = 1'b0;
        win_lvl   = 3'd7;
        isr_found = 1'b0;
        isr_lvl   = 3'd7;
        for (int i = 0; i < 8; i++) begin
            scan = lp_q + 3'(i + 1);
            if (!isr_found && isr_q[scan]) begin
                isr_found = 1'b1;
                isr_lvl   = scan;
            end
            if (!win_found && bus.irr_req[scan]) begin
                win_found = 1'b1;
                win_lvl   = scan;
                win_ok    = !isr_found;
            end
        end
        win_valid = win_found && win_ok;
    end

    always_comb begin
        state_n   = state;
        level_n   = level;
        int_n     = int_q;
        clr_n     = 8'h00;
        set_mask  = 8'h00;
        aeoi_mask = 8'h00;
        aeoi_rot  = 1'b0;
        case (state)
            IDLE: if (win_valid) begin
                state_n = REQ;
                int_n   = 1'b1;
            end
            REQ: if (fall) begin
                state_n = ACK1;
                int_n   = 1'b0;
                if (win_valid) begin
                    level_n  = win_lvl;
                    set_mask = 8'b1 << win_lvl;
                    clr_n    = 8'b1 << win_lvl;
                end else begin
                    level_n  = 3'd7;
                end
            end else if (!win_valid) begin
                state_n = IDLE;
                int_n   = 1'b0;
            end
            ACK1:  if (rise) state_n = WAIT2;
            WAIT2: if (fall) state_n = ACK2;
            ACK2: if (rise) begin
                state_n = IDLE;
                if (bus.aeoi_en) begin
                    aeoi_mask = 8'b1 << level;
                    aeoi_rot  = bus.aeoi_rotate;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Non-specific EOI targets the highest-priority in-service level; EOI rotation overrides AEOI rotation.
    always_comb begin
        eoi_mask    = 8'h00;
        eoi_rot     = 1'b0;
        eoi_rot_lvl = bus.eoi_level;
        if (bus.eoi_cmd) begin
            if (bus.eoi_specific) begin
                eoi_mask = 8'b1 << bus.eoi_level;
                eoi_rot  = bus.eoi_rotate;
            end else if (isr_found) begin
                eoi_mask    = 8'b1 << isr_lvl;
                eoi_rot     = bus.eoi_rotate;
                eoi_rot_lvl = isr_lvl;
            end
        end
        isr_n = (isr_q | set_mask) & ~(eoi_mask | aeoi_mask);
        lp_n  = eoi_rot ? eoi_rot_lvl : (aeoi_rot ? level : lp_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            inta_q <= 1'b1;
            level  <= 3'd7;
            isr_q  <= 8'h00;
            lp_q   <= 3'd7;
            int_q  <= 1'b0;
            clr_q  <= 8'h00;
        end else begin
            state  <= state_n;
            inta_q <= bus.inta_n;
            level  <= level_n;
            isr_q  <= isr_n;
            lp_q   <= lp_n;
            int_q  <= int_n;
            clr_q  <= clr_n;
        end
    end

    assign bus.int_out     = int_q;
    assign bus.irr_clr     = clr_q;
    assign bus.isr_cur     = isr_q;
    assign bus.lowest_prio = lp_q;
    assign bus.data_oe     = (state == ACK2);
    assign bus.data_out    = (state == ACK2) ? {bus.vector_base, level} : 8'h00;
    assign bus.fsm_state   = state;
endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Bench for pic_inta_sequencer: directed protocol scenarios plus randomized requests
// checked against a priority-scan reference model of the ISR and rotation rules.
module tb_pic_inta_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pic_inta_sequencer_if bus();

    pic_inta_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_isr;
    int         m_lp;

    // Samples captured by inta_seq
    logic       s_int_before, s_int_after, s_oe2, s_oe3;
    logic [7:0] s_clr, s_clr2, s_isr1, s_dout2, s_dout3, s_isr3;
    logic [2:0] s_lp3;

    function automatic int m_winner(logic [7:0] irr, logic [7:0] isr, int lp);
        for (int r = 0; r < 8; r++) begin
            int l;
            l = (lp + 1 + r) % 8;
            if (isr[l]) return -1;
            if (irr[l]) return l;
        end
        return -1;
    endfunction

    function automatic int m_top(logic [7:0] isr, int lp);
        for (int r = 0; r < 8; r++) begin
            int l;
            l = (lp + 1 + r) % 8;
            if (isr[l]) return l;
        end
        return -1;
    endfunction

    task automatic drive_eoi(input bit spec, input logic [2:0] lvl, input bit rot);
        bus.eoi_cmd      = 1'b1;
        bus.eoi_specific = spec;
        bus.eoi_level    = lvl;
        bus.eoi_rotate   = rot;
    endtask

    task automatic do_reset();
        bus.irr_req = 8'h00; bus.inta_n = 1'b1; bus.eoi_cmd = 1'b0;
        bus.eoi_specific = 1'b0; bus.eoi_level = 3'd0; bus.eoi_rotate = 1'b0;
        bus.aeoi_en = 1'b0; bus.aeoi_rotate = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_isr = 8'h00;
        m_lp  = 7;
        @(posedge clk); #1;
    endtask

    // Full two-pulse acknowledge; caller has set irr_req at posedge+1.
    task automatic inta_seq(input bit drop_at_fall, input int eoi_at, input bit spec,
                            input logic [2:0] lvl, input bit rot);
        @(posedge clk); #1;
        s_int_before = bus.int_out;
        bus.inta_n = 1'b0;
        if (drop_at_fall) bus.irr_req = 8'h00;
        if (eoi_at == 1) drive_eoi(spec, lvl, rot);
        @(posedge clk); #1;
        s_clr = bus.irr_clr; s_int_after = bus.int_out; s_isr1 = bus.isr_cur;
        bus.eoi_cmd = 1'b0;
        bus.irr_req = bus.irr_req & ~bus.irr_clr;
        bus.inta_n = 1'b1;
        @(posedge clk); #1;
        s_clr2 = bus.irr_clr;
        bus.inta_n = 1'b0;
        @(posedge clk); #1;
        s_oe2 = bus.data_oe; s_dout2 = bus.data_out;
        bus.inta_n = 1'b1;
        if (eoi_at == 2) drive_eoi(spec, lvl, rot);
        @(posedge clk); #1;
        s_oe3 = bus.data_oe; s_dout3 = bus.data_out; s_isr3 = bus.isr_cur; s_lp3 = bus.lowest_prio;
        bus.eoi_cmd = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.int_out !== 1'b0) begin n_fail++; $display("FAIL reset_int_out: got %b expected 0", bus.int_out); end
        n_checks++; if (bus.irr_clr !== 8'h00) begin n_fail++; $display("FAIL reset_irr_clr: got %h expected 00", bus.irr_clr); end
        n_checks++; if (bus.isr_cur !== 8'h00) begin n_fail++; $display("FAIL reset_isr: got %h expected 00", bus.isr_cur); end
        n_checks++; if (bus.data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe: got %b expected 0", bus.data_oe); end
        n_checks++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00", bus.data_out); end
        n_checks++; if (bus.lowest_prio !== 3'd7) begin n_fail++; $display("FAIL reset_lowest_prio: got %0d expected 7", bus.lowest_prio); end
    endtask

    task automatic test_fixed_priority();
        bus.vector_base = 5'b10000;
        bus.irr_req = 8'b0000_0110;
        inta_seq(1'b0, 0, 1'b0, 3'd0, 1'b0);
        n_checks++; if (s_int_before !== 1'b1) begin n_fail++; $display("FAIL fixed_int_before: got %b expected 1", s_int_before); end
        n_checks++; if (s_int_after !== 1'b0) begin n_fail++; $display("FAIL fixed_int_after: got %b expected 0", s_int_after); end
        n_checks++; if (s_clr !== 8'h02) begin n_fail++; $display("FAIL fixed_irr_clr: got %h expected 02", s_clr); end
        n_checks++; if (s_isr1 !== 8'h02) begin n_fail++; $display("FAIL fixed_isr: got %h expected 02", s_isr1); end
        n_checks++; if (s_clr2 !== 8'h00) begin n_fail++; $display("FAIL fixed_clr_pulse_width: got %h expected 00", s_clr2); end
        n_checks++; if (s_oe2 !== 1'b1) begin n_fail++; $display("FAIL fixed_data_oe: got %b expected 1", s_oe2); end
        n_checks++; if (s_dout2 !== 8'h81) begin n_fail++; $display("FAIL fixed_vector: got %h expected 81", s_dout2); end
        n_checks++; if (s_oe3 !== 1'b0 || s_dout3 !== 8'h00) begin n_fail++; $display("FAIL fixed_release: got oe=%b out=%h expected oe=0 out=00", s_oe3, s_dout3); end
        bus.irr_req = 8'h00;
        m_isr = 8'h02;
    endtask

    task automatic test_nesting();
        bus.irr_req = 8'b0000_0001;
        inta_seq(1'b0, 0, 1'b0, 3'd0, 1'b0);
        n_checks++; if (s_int_before !== 1'b1) begin n_fail++; $display("FAIL nest_int_before: got %b expected 1", s_int_before); end
        n_checks++; if (s_clr !== 8'h01) begin n_fail++; $display("FAIL nest_irr_clr: got %h expected 01", s_clr); end
        n_checks++; if (s_isr3 !== 8'h03) begin n_fail++; $display("FAIL nest_isr: got %h expected 03", s_isr3); end
        m_isr = 8'h03;
        bus.irr_req = 8'b0000_1000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++; if (bus.int_out !== 1'b0) begin n_fail++; $display("FAIL nest_blocked_ir3 cycle %0d: got %b expected 0", i, bus.int_out); end
        end
        bus.irr_req = 8'h00;
    endtask

    task automatic test_eoi_nonspecific();
        drive_eoi(1'b0, 3'd0, 1'b0);
        @(posedge clk); #1; bus.eoi_cmd = 1'b0;
        n_checks++; if (bus.isr_cur !== 8'h02) begin n_fail++; $display("FAIL eoi_first: got %h expected 02", bus.isr_cur); end
        drive_eoi(1'b0, 3'd0, 1'b0);
        @(posedge clk); #1; bus.eoi_cmd = 1'b0;
        n_checks++; if (bus.isr_cur !== 8'h00) begin n_fail++; $display("FAIL eoi_second: got %h expected 00", bus.isr_cur); end
        drive_eoi(1'b0, 3'd0, 1'b1);
        @(posedge clk); #1; bus.eoi_cmd = 1'b0;
        n_checks++; if (bus.isr_cur !== 8'h00 || bus.lowest_prio !== 3'd7) begin n_fail++; $display("FAIL eoi_empty: got isr=%h lp=%0d expected isr=00 lp=7", bus.isr_cur, bus.lowest_prio); end
        m_isr = 8'h00;
    endtask

    task automatic test_aeoi_rotate();
        bus.aeoi_en = 1'b1; bus.aeoi_rotate = 1'b1;
        bus.irr_req = 8'b0001_0000;
        inta_seq(1'b0, 0, 1'b0, 3'd0, 1'b0);
        n_checks++; if (s_clr !== 8'h10) begin n_fail++; $display("FAIL aeoi_irr_clr: got %h expected 10", s_clr); end
        n_checks++; if (s_isr1 !== 8'h10) begin n_fail++; $display("FAIL aeoi_isr_set: got %h expected 10", s_isr1); end
        n_checks++; if (s_dout2 !== 8'h84) begin n_fail++; $display("FAIL aeoi_vector: got %h expected 84", s_dout2); end
        n_checks++; if (s_isr3 !== 8'h00) begin n_fail++; $display("FAIL aeoi_isr_clear: got %h expected 00", s_isr3); end
        n_checks++; if (s_lp3 !== 3'd4) begin n_fail++; $display("FAIL aeoi_lowest_prio: got %0d expected 4", s_lp3); end
        bus.irr_req = 8'b0001_0001;
        inta_seq(1'b0, 0, 1'b0, 3'd0, 1'b0);
        n_checks++; if (s_clr !== 8'h01) begin n_fail++; $display("FAIL aeoi_rotated_winner: got %h expected 01", s_clr); end
        n_checks++; if (s_lp3 !== 3'd0) begin n_fail++; $display("FAIL aeoi_second_rotate: got %0d expected 0", s_lp3); end
        bus.irr_req = 8'h00;
        bus.aeoi_en = 1'b0; bus.aeoi_rotate = 1'b0;
    endtask

    task automatic test_spurious();
        do_reset();
        bus.vector_base = 5'b01010;
        bus.irr_req = 8'h04;
        @(posedge clk); #1;
        n_checks++; if (bus.int_out !== 1'b1) begin n_fail++; $display("FAIL spur_int_rise: got %b expected 1", bus.int_out); end
        bus.irr_req = 8'h00;
        @(posedge clk); #1;
        n_checks++; if (bus.int_out !== 1'b0) begin n_fail++; $display("FAIL spur_withdraw: got %b expected 0", bus.int_out); end
        bus.inta_n = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus.isr_cur !== 8'h00 || bus.data_oe !== 1'b0 || bus.irr_clr !== 8'h00) begin n_fail++; $display("FAIL idle_inta_ignored: got isr=%h oe=%b clr=%h expected 00/0/00", bus.isr_cur, bus.data_oe, bus.irr_clr); end
        bus.inta_n = 1'b1;
        @(posedge clk); #1;
        bus.irr_req = 8'h04;
        inta_seq(1'b1, 0, 1'b0, 3'd0, 1'b0);
        n_checks++; if (s_int_before !== 1'b1) begin n_fail++; $display("FAIL spur2_int_before: got %b expected 1", s_int_before); end
        n_checks++; if (s_clr !== 8'h00) begin n_fail++; $display("FAIL spur2_irr_clr: got %h expected 00", s_clr); end
        n_checks++; if (s_isr1 !== 8'h00) begin n_fail++; $display("FAIL spur2_isr: got %h expected 00", s_isr1); end
        n_checks++; if (s_dout2 !== 8'h57) begin n_fail++; $display("FAIL spur2_vector: got %h expected 57", s_dout2); end
    endtask

    task automatic test_coincident();
        do_reset();
        bus.vector_base = 5'b00001;
        bus.irr_req = 8'h04;
        inta_seq(1'b0, 0, 1'b0, 3'd0, 1'b0);
        n_checks++; if (s_isr3 !== 8'h04) begin n_fail++; $display("FAIL coin_setup_isr: got %h expected 04", s_isr3); end
        bus.irr_req = 8'h02;
        inta_seq(1'b0, 1, 1'b1, 3'd2, 1'b0);
        n_checks++; if (s_isr1 !== 8'h02) begin n_fail++; $display("FAIL coin_ack1_eoi: got %h expected 02", s_isr1); end
        bus.aeoi_en = 1'b1; bus.aeoi_rotate = 1'b1;
        bus.irr_req = 8'h01;
        inta_seq(1'b0, 2, 1'b1, 3'd1, 1'b1);
        n_checks++; if (s_isr1 !== 8'h03) begin n_fail++; $display("FAIL coin_nest_isr: got %h expected 03", s_isr1); end
        n_checks++; if (s_isr3 !== 8'h00) begin n_fail++; $display("FAIL coin_aeoi_eoi_isr: got %h expected 00", s_isr3); end
        n_checks++; if (s_lp3 !== 3'd1) begin n_fail++; $display("FAIL coin_rotate_priority: got %0d expected 1", s_lp3); end
        bus.aeoi_en = 1'b0; bus.aeoi_rotate = 1'b0;
        bus.irr_req = 8'h00;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.irr_req = 8'h04;
        @(posedge clk); #1;
        bus.inta_n = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus.isr_cur !== 8'h04) begin n_fail++; $display("FAIL rmid_isr_before: got %h expected 04", bus.isr_cur); end
        bus.irr_req = 8'h00; bus.inta_n = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0; bus.inta_n = 1'b0;
        #1;
        n_checks++; if (bus.isr_cur !== 8'h00 || bus.lowest_prio !== 3'd7) begin n_fail++; $display("FAIL rmid_isr_lp: got isr=%h lp=%0d expected 00/7", bus.isr_cur, bus.lowest_prio); end
        n_checks++; if (bus.int_out !== 1'b0 || bus.irr_clr !== 8'h00) begin n_fail++; $display("FAIL rmid_int_clr: got int=%b clr=%h expected 0/00", bus.int_out, bus.irr_clr); end
        n_checks++; if (bus.data_oe !== 1'b0 || bus.data_out !== 8'h00) begin n_fail++; $display("FAIL rmid_data: got oe=%b out=%h expected 0/00", bus.data_oe, bus.data_out); end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        bus.inta_n = 1'b1;
        @(posedge clk); #1;
        bus.inta_n = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus.data_oe !== 1'b0 || bus.isr_cur !== 8'h00 || bus.int_out !== 1'b0) begin n_fail++; $display("FAIL rmid_inta_ignored: got oe=%b isr=%h int=%b expected 0/00/0", bus.data_oe, bus.isr_cur, bus.int_out); end
        bus.inta_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [7:0] irr, exp_clr, exp_isr1, exp_isr3;
        int w, top;
        bit spec, rot;
        logic [2:0] lvl;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            irr = 8'($urandom_range(1, 255));
            bus.vector_base = 5'($urandom);
            bus.aeoi_en     = 1'($urandom_range(0, 1));
            bus.aeoi_rotate = 1'($urandom_range(0, 1));
            w = m_winner(irr, m_isr, m_lp);
            bus.irr_req = irr;
            if (w < 0) begin
                @(posedge clk); #1;
                n_checks++; if (bus.int_out !== 1'b0) begin n_fail++; $display("FAIL rnd_blocked it%0d: got %b expected 0 (irr=%h isr=%h)", it, bus.int_out, irr, m_isr); end
            end else begin
                inta_seq(1'b0, 0, 1'b0, 3'd0, 1'b0);
                exp_clr  = 8'b1 << w;
                exp_isr1 = m_isr | exp_clr;
                exp_isr3 = bus.aeoi_en ? (exp_isr1 & ~exp_clr) : exp_isr1;
                if (bus.aeoi_en && bus.aeoi_rotate) m_lp = w;
                m_isr = exp_isr3;
                n_checks++; if (s_int_before !== 1'b1) begin n_fail++; $display("FAIL rnd_int it%0d: got %b expected 1", it, s_int_before); end
                n_checks++; if (s_clr !== exp_clr) begin n_fail++; $display("FAIL rnd_irr_clr it%0d: got %h expected %h", it, s_clr, exp_clr); end
                n_checks++; if (s_isr1 !== exp_isr1) begin n_fail++; $display("FAIL rnd_isr_ack it%0d: got %h expected %h", it, s_isr1, exp_isr1); end
                n_checks++; if (s_dout2 !== {bus.vector_base, 3'(w)}) begin n_fail++; $display("FAIL rnd_vector it%0d: got %h expected %h", it, s_dout2, {bus.vector_base, 3'(w)}); end
                n_checks++; if (s_isr3 !== exp_isr3 || s_lp3 !== 3'(m_lp)) begin n_fail++; $display("FAIL rnd_end it%0d: got isr=%h lp=%0d expected %h/%0d", it, s_isr3, s_lp3, exp_isr3, m_lp); end
            end
            bus.irr_req = 8'h00;
            repeat (2) @(posedge clk); #1;
            if ($urandom_range(0, 1) == 1) begin
                spec = 1'($urandom_range(0, 1));
                rot  = 1'($urandom_range(0, 1));
                lvl  = 3'($urandom_range(0, 7));
                drive_eoi(spec, lvl, rot);
                @(posedge clk); #1;
                bus.eoi_cmd = 1'b0;
                if (spec) begin
                    m_isr[lvl] = 1'b0;
                    if (rot) m_lp = int'(lvl);
                end else begin
                    top = m_top(m_isr, m_lp);
                    if (top >= 0) begin
                        m_isr[top] = 1'b0;
                        if (rot) m_lp = top;
                    end
                end
                n_checks++; if (bus.isr_cur !== m_isr || bus.lowest_prio !== 3'(m_lp)) begin n_fail++; $display("FAIL rnd_eoi it%0d: got isr=%h lp=%0d expected %h/%0d", it, bus.isr_cur, bus.lowest_prio, m_isr, m_lp); end
            end
        end
    endtask

    initial begin
        bus.vector_base = 5'd0;
        test_reset();
        test_fixed_priority();
        test_nesting();
        test_eoi_nonspecific();
        test_aeoi_rotate();
        test_spurious();
        test_coincident();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pic_inta_sequencer.md
PIC_INTA_SEQUENCER -- requirements
Module: pic_inta_sequencer

Interface
REQ-001 clk  input  1  system clock; all state updates on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 irr_req  input  8  pending requests, already masked; bit i = IR level i.
REQ-004 inta_n  input  1  interrupt acknowledge from CPU, active-low, pre-synchronised to clk; edges are detected against a registered copy.
REQ-005 eoi_cmd  input  1  one-cycle EOI command strobe.
REQ-006 eoi_specific  input  1  qualifies eoi_cmd: 1 = specific EOI on eoi_level, 0 = non-specific.
REQ-007 eoi_level  input  3  target level for a specific EOI.
REQ-008 eoi_rotate  input  1  qualifies eoi_cmd: 1 = cleared level becomes lowest priority.
REQ-009 aeoi_en  input  1  automatic EOI mode enable.
REQ-010 aeoi_rotate  input  1  in AEOI mode, the auto-cleared level becomes lowest priority.
REQ-011 vector_base  input  5  vector bits T7..T3.
REQ-012 int_out  output  1  interrupt request to CPU, active-high.
REQ-013 irr_clr  output  8  one-hot, one-cycle pulse clearing the acknowledged IRR bit.
REQ-014 isr_cur  output  8  in-service register contents.
REQ-015 data_out  output  8  vector byte {vector_base, level}.
REQ-016 data_oe  output  1  data_out valid/drive enable.
REQ-017 lowest_prio  output  3  current lowest-priority level.

Function
REQ-018 Priority order SHALL be (lowest_prio+1)%8 highest, descending cyclically to lowest_prio.
REQ-019 Winner SHALL be the highest-priority set bit of irr_req; a winner is valid only if it outranks every set isr_cur bit, or isr_cur == 0.
REQ-020 FSM states SHALL be IDLE, REQ, ACK1, WAIT2, ACK2.
REQ-021 IDLE: a valid winner -> REQ; int_out SHALL be 1 from the cycle REQ is entered.
REQ-022 REQ: the winner SHALL be re-evaluated every cycle; if no valid winner remains -> IDLE with int_out = 0.
REQ-023 REQ + inta_n falling edge -> ACK1, and in the same transition:
  - latch level = current winner, or 7 if none (spurious);
  - set isr_cur[level], except for a spurious request;
  - pulse irr_clr[level] for one cycle, except for a spurious request;
  - drive int_out = 0.
REQ-024 ACK1 + inta_n rising edge -> WAIT2.
REQ-025 WAIT2 + inta_n falling edge -> ACK2; data_oe = 1 and data_out = {vector_base, level} while in ACK2.
REQ-026 ACK2 + inta_n rising edge -> IDLE with data_oe = 0.
  - If aeoi_en = 1, clear isr_cur[level] on this transition.
  - If aeoi_rotate = 1 as well, set lowest_prio = level.
REQ-027 An inta_n falling edge in IDLE SHALL be ignored: no ISR change, data_oe stays 0.
REQ-028 eoi_cmd, non-specific: clear the highest-priority set isr_cur bit (per REQ-018); if eoi_rotate = 1, lowest_prio = that level; no effect if isr_cur == 0.
REQ-029 eoi_cmd, specific: clear isr_cur[eoi_level]; if eoi_rotate = 1, lowest_prio = eoi_level; the clear applies even if the bit is already 0.
REQ-030 EOI and an AEOI clear or an ACK1 set in the same cycle SHALL all take effect; both the set and the clear are applied to isr_cur.
REQ-031 If EOI rotate and AEOI rotate coincide, the EOI rotate SHALL win.
REQ-032 data_out SHALL be 8'h00 whenever data_oe = 0.
REQ-033 isr_cur, lowest_prio and int_out SHALL be registered outputs; irr_clr SHALL be a registered pulse.

Reset
REQ-034 rst_n low SHALL immediately force:
  - state = IDLE, isr_cur = 0, lowest_prio = 7;
  - int_out = 0, irr_clr = 0, data_oe = 0, data_out = 0;
  - the registered inta_n copy = 1.
REQ-035 Reset asserted mid-acknowledge SHALL abort the cycle; after release, a new cycle needs a new REQ; inta_n low at reset release SHALL NOT produce a falling edge.

Verification
REQ-036 Fixed priority: irr_req = 8'b00000110, vector_base = 5'b10000, two INTA pulses.
  - First INTA: int_out = 1 before, then 0; irr_clr = 8'b00000010; isr_cur = 8'b00000010.
  - Second INTA: data_out = 8'h81.
REQ-037 Nesting: IR1 in service, then irr_req = 8'b00000001 -> int_out = 1, IR0 acknowledged, isr_cur = 8'b00000011.
  - Then irr_req = 8'b00001000 (IR3) -> int_out stays 0.
REQ-038 Non-specific EOI with isr_cur = 8'b00000011 -> isr_cur = 8'b00000010; a second EOI -> 8'b00000000.
REQ-039 AEOI with rotation: aeoi_en = 1, aeoi_rotate = 1, IR4 acknowledged.
  - After the second INTA rising edge: isr_cur = 0, lowest_prio = 4.
  - Then irr_req = 8'b00010001 -> IR0 wins over IR4.
REQ-040 Spurious: irr_req drops to 0 after int_out rises but before the first INTA falling edge -> REQ returns to IDLE.
  - Variant, request drops in the same cycle as the first INTA falling edge: data_out = {vector_base, 3'b111}, isr_cur unchanged.
REQ-041 Reset mid-sequence: rst_n pulsed low in WAIT2 with isr_cur = 8'b00000100 -> all outputs at reset values at once; a later inta_n falling edge is ignored.
